pulse_delay_queue: RTL and testbench
====================================

// Module: pulse_delay_queue
// PURPOSE
//  Upstream conditioning stage on the bit bus. Timestamps rising edges of
//  INP_i and replays each one DELAY+3 clocks later as a WIDTH-clock pulse on
//  OUT_o, which feeds the single-bit inputs of downstream logic blocks.
//  Pending edges are buffered in a small timestamp queue. Overflow is counted.
// PARAMETERS
//  QUEUE_DEPTH  16  number of pending edges held; power of two, 2..256
//  TS_W         48  width of internal tick counter and stored due-times
// PORTS
//  clk_i       in   1   system clock; all logic on posedge
//  reset_i     in   1   asynchronous, active-high reset
//  INP_i       in   1   input bit; rising edges are queued
//  ENABLE_i    in   1   block enable; low = idle and flushed
//  DELAY       in   32  extra delay in clocks (register)
//  DELAY_wstb  in   1   one-cycle write strobe for DELAY
//  WIDTH       in   32  output pulse width in clocks (register); 0 treated as 1
//  WIDTH_wstb  in   1   one-cycle write strobe for WIDTH
//  OUT_o       out  1   delayed/stretched pulse output
//  QUEUED_o    out  clog2(QUEUE_DEPTH)+1  current queue occupancy
//  DROPPED_o   out  16  edges lost to full queue; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset_i=1, any time, async): OUT_o=0, QUEUED_o=0, DROPPED_o=0,
//   tick=0, queue empty, width counter=0, INP_i history=0.
//  Tick: TS_W-bit counter, +1 per clock while ENABLE_i=1; held at 0 while low.
//   Wraps modulo 2^TS_W. Due-time compare uses equality, so wrap is harmless.
//  Edge detect: INP_i=1 at edge T with INP_i=0 at edge T-1, ENABLE_i=1.
//   At edge T+1, push due=tick(T)+DELAY+2 (TS_W arithmetic, DELAY zero-extended).
//  Pop: when queue non-empty and tick==head.due, pop head. On the same edge,
//   load width counter with max(WIDTH,1). OUT_o=1 from edge T+DELAY+3.
//  Pulse: OUT_o=1 while width counter>0. Decrement once per clock.
//   A pop while OUT_o=1 retriggers: reload counter, OUT_o stays 1 (no gap).
//   DELAY=0, WIDTH=1: single-clock pulse exactly 3 clocks after the edge.
//  Full: push attempted with QUEUED_o==QUEUE_DEPTH and no pop that cycle:
//   edge discarded, DROPPED_o+1 (saturating).
//   Push and pop in the same cycle with queue full: both succeed, no drop.
//  Empty: no pop. OUT_o finishes any pulse in progress.
//  DELAY_wstb or WIDTH_wstb=1:
//   - flush queue, QUEUED_o=0, width counter=0;
//   - OUT_o=0 from the next edge;
//   - an edge detected in the same cycle is discarded, not counted as dropped;
//   - the new value applies to edges after the strobe.
//  ENABLE_i 1->0: next edge flushes queue, OUT_o=0, tick=0.
//   DROPPED_o holds its value. Edges are ignored while low.
//  ENABLE_i 0->1: clears DROPPED_o. Edge detect history is reset, so INP_i
//   already high is not an edge until it goes low then high again.
//  Occupancy: QUEUED_o registered; it updates on the edge that pushes or pops.
//  Latency is fixed at DELAY+3 whatever the queue occupancy. Ordering is FIFO.
// TESTING
//  1 DELAY=0,WIDTH=1, INP rise at T -> OUT_o high only at T+3; QUEUED 1 then 0.
//  2 DELAY=10,WIDTH=4, INP rises at T,T+2 -> OUT_o high T+13..T+18 (retrigger,
//    no gap), QUEUED_o peaks at 2.
//  3 QUEUE_DEPTH=16,DELAY=1000, 20 edges every 4 clk -> QUEUED_o=16,
//    DROPPED_o=4, exactly 16 output pulses spaced 4 clk, first at T0+1003.
//  4 DELAY=100, 3 edges queued, DELAY_wstb at T+50 -> QUEUED_o=0 at T+51,
//    no OUT_o pulse thereafter, DROPPED_o unchanged.
//  5 ENABLE_i drop mid-pulse (WIDTH=50) -> OUT_o=0 next clk. Re-enable with
//    INP_i held high -> no pulse until INP_i low then high.
//  6 reset_i pulsed mid-pulse, not clock-aligned -> OUT_o, QUEUED_o, DROPPED_o
//    =0 immediately; after release, DELAY=0 edge gives OUT_o at +3.

Source files
------------

// File: rtl/pulse_delay_queue_if.sv
// Bit-bus bundle for pulse_delay_queue: input bit, enable, DELAY/WIDTH register writes and status outputs.
// The master side drives the inputs. The slave side is the queue itself.
interface pulse_delay_queue_if #(
  parameter int QUEUE_DEPTH = 16
);
  logic                           INP_i;
  logic                           ENABLE_i;
  logic [31:0]                    DELAY;
  logic                           DELAY_wstb;
  logic [31:0]                    WIDTH;
  logic                           WIDTH_wstb;
  logic                           OUT_o;
  logic [$clog2(QUEUE_DEPTH):0]   QUEUED_o;
  logic [15:0]                    DROPPED_o;

  modport master (
    output INP_i, ENABLE_i, DELAY, DELAY_wstb, WIDTH, WIDTH_wstb,
    input  OUT_o, QUEUED_o, DROPPED_o
  );

  modport slave (
    input  INP_i, ENABLE_i, DELAY, DELAY_wstb, WIDTH, WIDTH_wstb,
    output OUT_o, QUEUED_o, DROPPED_o
  );
endinterface

// File: rtl/pulse_delay_queue.sv
// Timestamps rising edges of INP_i and replays each one DELAY+3 clocks later as a WIDTH-clock pulse.
// Pending due-times wait in a FIFO, and the pulse comes out when the free-running tick equals the due-time at the head.
module pulse_delay_queue #(
  parameter int QUEUE_DEPTH = 16,
  parameter int TS_W        = 48
) (
  input logic               clk_i,
  input logic               reset_i,
  pulse_delay_queue_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);

  logic [TS_W-1:0] r_tick;
  logic [31:0]     r_delay;
  logic [31:0]     r_width;
  logic [31:0]     r_cnt;
  logic            r_inp_d;
  logic            r_en_d;
  logic            r_edge;
  logic [TS_W-1:0] r_due [QUEUE_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [15:0]     r_dropped;

  logic            w_flush;
  logic            w_full;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic [TS_W-1:0] w_due;
  logic [31:0]     w_width_eff;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_flush     = !bus.ENABLE_i || bus.DELAY_wstb || bus.WIDTH_wstb;
    w_full      = (r_count == (AW+1)'(QUEUE_DEPTH));
    w_pop       = !w_flush && (r_count != '0) && (r_due[r_rd_ptr] == r_tick);
    w_push_req  = !w_flush && r_edge;
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = w_push_req && w_full && !w_pop;
    // The edge was seen one clock ago. r_tick already holds that edge's post-increment tick.
    w_due       = r_tick + TS_W'(r_delay) + TS_W'(2);
    w_width_eff = (r_width == '0) ? 32'd1 : r_width;
  end

  // NOTE: storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_due[r_wr_ptr] <= w_due;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tick    <= '0;
      r_delay   <= '0;
      r_width   <= '0;
      r_cnt     <= '0;
      r_inp_d   <= 1'b0;
      r_en_d    <= 1'b0;
      r_edge    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= '0;
    end else begin
      // The history register keeps tracking INP_i while disabled, so a level that is already high on re-enable does not count as an edge.
      r_inp_d <= bus.INP_i;
      r_en_d  <= bus.ENABLE_i;
      r_edge  <= !w_flush && bus.INP_i && !r_inp_d;
      r_tick  <= bus.ENABLE_i ? r_tick + TS_W'(1) : '0;

      if (bus.DELAY_wstb) r_delay <= bus.DELAY;
      if (bus.WIDTH_wstb) r_width <= bus.WIDTH;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end

      // A pop during a pulse reloads the counter, so the output has no gap.
      if (w_flush)            r_cnt <= '0;
      else if (w_pop)         r_cnt <= w_width_eff;
      else if (r_cnt != '0)   r_cnt <= r_cnt - 32'd1;

      if (bus.ENABLE_i && !r_en_d)              r_dropped <= '0;
      else if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
    end
  end

  assign bus.OUT_o     = (r_cnt != '0);
  assign bus.QUEUED_o  = r_count;
  assign bus.DROPPED_o = r_dropped;
endmodule

// File: tb/tb_pulse_delay_queue.sv
// Directed bench for pulse_delay_queue. Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Expected values are worked out by hand from the edge timing and the configured DELAY and WIDTH.
module tb_pulse_delay_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   n_hi;
  int   n_bad;

  always #5 clk = ~clk;

  pulse_delay_queue_if #(.QUEUE_DEPTH(16)) bus ();

  pulse_delay_queue #(.QUEUE_DEPTH(16), .TS_W(48)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_delay(input logic [31:0] v);
    bus.DELAY = v;
    bus.DELAY_wstb = 1'b1;
    step(1);
    bus.DELAY_wstb = 1'b0;
  endtask

  task automatic write_width(input logic [31:0] v);
    bus.WIDTH = v;
    bus.WIDTH_wstb = 1'b1;
    step(1);
    bus.WIDTH_wstb = 1'b0;
  endtask

  initial begin
    bus.INP_i = 1'b0; bus.ENABLE_i = 1'b1;
    bus.DELAY = '0; bus.DELAY_wstb = 1'b0;
    bus.WIDTH = '0; bus.WIDTH_wstb = 1'b0;
    #1;
    check("rst_out", bus.OUT_o, 0);
    check("rst_queued", bus.QUEUED_o, 0);
    check("rst_dropped", bus.DROPPED_o, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step(1);

    // 1: DELAY=0, WIDTH=1 -> single pulse at T+3
    write_delay(0);
    write_width(1);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0;
    check("t1_queued_T", bus.QUEUED_o, 0);
    step(1); check("t1_queued_T1", bus.QUEUED_o, 1); check("t1_out_T1", bus.OUT_o, 0);
    step(1); check("t1_out_T2", bus.OUT_o, 0);
    step(1); check("t1_out_T3", bus.OUT_o, 1); check("t1_queued_T3", bus.QUEUED_o, 0);
    step(1); check("t1_out_T4", bus.OUT_o, 0);

    // 2: DELAY=10, WIDTH=4, edges at T and T+2 -> high T+13..T+18
    write_delay(10);
    write_width(4);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0; step(1);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0; step(1);
    check("t2_queued_peak", bus.QUEUED_o, 2);
    step(9); check("t2_out_T12", bus.OUT_o, 0);
    for (int i = 0; i < 6; i++) begin
      step(1); check("t2_out_hi", bus.OUT_o, 1);
    end
    step(1); check("t2_out_T19", bus.OUT_o, 0);
    check("t2_queued_end", bus.QUEUED_o, 0);

    // 3: DELAY=1000, 20 edges every 4 clocks -> 16 held, 4 dropped
    write_delay(1000);
    write_width(1);
    for (int k = 0; k < 20; k++) begin
      bus.INP_i = 1'b1; step(1);
      bus.INP_i = 1'b0; step(3);
    end
    check("t3_queued_full", bus.QUEUED_o, 16);
    check("t3_dropped", bus.DROPPED_o, 4);
    step(923); check("t3_out_T1002", bus.OUT_o, 0);
    n_hi = 0; n_bad = 0;
    for (int c = 0; c < 80; c++) begin
      step(1);
      if (bus.OUT_o) n_hi++;
      if (bus.OUT_o !== ((c % 4 == 0) && (c < 64))) n_bad++;
    end
    check("t3_pulse_count", n_hi, 16);
    check("t3_pulse_timing", n_bad, 0);
    check("t3_queued_end", bus.QUEUED_o, 0);

    // 4: DELAY=100, 3 queued, strobe flushes -> no output afterwards
    write_delay(100);
    for (int k = 0; k < 3; k++) begin
      bus.INP_i = 1'b1; step(1);
      bus.INP_i = 1'b0; step(1);
    end
    check("t4_queued", bus.QUEUED_o, 3);
    step(45);
    bus.DELAY = 100; bus.DELAY_wstb = 1'b1; step(1);
    bus.DELAY_wstb = 1'b0;
    check("t4_queued_flushed", bus.QUEUED_o, 0);
    n_hi = 0;
    for (int c = 0; c < 150; c++) begin
      step(1);
      if (bus.OUT_o !== 1'b0) n_hi++;
    end
    check("t4_no_pulse", n_hi, 0);
    check("t4_dropped_held", bus.DROPPED_o, 4);

    // 6: asynchronous reset mid-pulse, then DELAY=0 edge -> +3
    write_width(50);
    write_delay(0);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0; step(5);
    check("t6_out_pre", bus.OUT_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out", bus.OUT_o, 0);
    check("t6_rst_queued", bus.QUEUED_o, 0);
    check("t6_rst_dropped", bus.DROPPED_o, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0; step(2);
    check("t6_out_T2", bus.OUT_o, 0);
    step(1); check("t6_out_T3", bus.OUT_o, 1);
    step(1); check("t6_out_T4", bus.OUT_o, 0);

    // 5: disable mid-pulse, re-enable with INP_i already high
    write_delay(200);
    write_width(50);
    for (int k = 0; k < 18; k++) begin
      bus.INP_i = 1'b1; step(1);
      bus.INP_i = 1'b0; step(1);
    end
    check("t5_queued_full", bus.QUEUED_o, 16);
    check("t5_dropped", bus.DROPPED_o, 2);
    write_delay(0);
    check("t5_queued_flush", bus.QUEUED_o, 0);
    bus.INP_i = 1'b1; step(1);
    bus.INP_i = 1'b0; step(3);
    check("t5_out_start", bus.OUT_o, 1);
    step(10); check("t5_out_mid", bus.OUT_o, 1);
    bus.ENABLE_i = 1'b0; step(1);
    check("t5_out_disabled", bus.OUT_o, 0);
    check("t5_queued_disabled", bus.QUEUED_o, 0);
    check("t5_dropped_hold", bus.DROPPED_o, 2);
    bus.INP_i = 1'b1; step(3);
    bus.ENABLE_i = 1'b1; step(1);
    check("t5_dropped_clear", bus.DROPPED_o, 0);
    n_hi = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (bus.OUT_o !== 1'b0) n_hi++;
    end
    check("t5_no_pulse_high", n_hi, 0);
    check("t5_queued_high", bus.QUEUED_o, 0);
    bus.INP_i = 1'b0; step(1);
    bus.INP_i = 1'b1; step(1);
    step(2); check("t5_out_T2", bus.OUT_o, 0);
    step(1); check("t5_out_T3", bus.OUT_o, 1);
    bus.INP_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
